mem_port_arbiter: RTL and testbench

Shares the CPU's single 16-bit data-memory port between the CPU load/store/stack path and one auxiliary requester (DMA engine or debug port). The CPU has priority, and the auxiliary side is granted idle cycles. A starvation counter can force grant windows, during which the CPU is stalled. The block sits between the CPU data port and the data RAM, and it adds a stall input to the CPU pipeline.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the CPU data-memory port with one auxiliary requester (DMA or debug).
// Define ARB_STARVE_EN to enable the starvation counter and forced grant windows.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic        aux_lock,
    input  logic [15:0] aux_addr,
    input  logic [15:0] aux_wdata,
    input  logic        aux_we,
    output logic        aux_gnt,
    output logic [15:0] aux_rdata,
    output logic        aux_rvalid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_AUX = 2'd1
    } state_t;

    localparam bit PARAMS_OK = (STARVE_LIMIT >= 2) && (STARVE_LIMIT <= 255) &&
                               (BURST_MAX >= 1) && (BURST_MAX <= 15);
    localparam bit BURST_EN = (BURST_MAX > 1);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("mem_port_arbiter: STARVE_LIMIT or BURST_MAX out of range");
    end

    state_t     state;
    logic [3:0] burst_cnt;
    logic       forced;
    logic       aux_read;

`ifdef ARB_STARVE_EN
    localparam logic [7:0] FORCE_AT = 8'(STARVE_LIMIT - 1);

    logic [7:0] wait_cnt;

    assign forced = (wait_cnt == FORCE_AT);

    // Counts consecutive cycles an aux request has lost to the CPU; saturates at the force point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (aux_gnt || !aux_req) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != FORCE_AT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        aux_gnt = 1'b0;
        if (state == S_AUX) begin
            aux_gnt = aux_req;
        end else begin
            aux_gnt = aux_req & (~cpu_req | forced);
        end
    end

    assign cpu_stall = cpu_req & aux_gnt;
    assign aux_read  = aux_gnt & ~aux_we;
    assign cpu_rdata = mem_rdata;

    assign mem_addr  = aux_gnt ? aux_addr  : cpu_addr;
    assign mem_wdata = aux_gnt ? aux_wdata : cpu_wdata;
    assign mem_we    = aux_gnt ? aux_we    : (cpu_req & cpu_we);

    // Ownership FSM plus the registered aux read return path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_CPU;
            burst_cnt  <= 4'd0;
            aux_rdata  <= 16'h0000;
            aux_rvalid <= 1'b0;
        end else begin
            aux_rvalid <= aux_read;
            if (aux_read) begin
                aux_rdata <= mem_rdata;
            end
            case (state)
                S_CPU: begin
                    if (aux_gnt && aux_lock && BURST_EN) begin
                        state     <= S_AUX;
                        burst_cnt <= 4'd1;
                    end
                end
                S_AUX: begin
                    // A dropped request or lock ends the window so the CPU owns the next cycle.
                    if (aux_req && aux_lock && (burst_cnt < BURST_LAST)) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        state     <= S_CPU;
                        burst_cnt <= 4'd0;
                    end
                end
                default: begin
                    state     <= S_CPU;
                    burst_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: combinational grant/mux checks plus a
// scoreboard of expected aux read data popped whenever aux_rvalid pulses.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int BURST_MAX    = 4;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        aux_req;
    logic        aux_lock;
    logic [15:0] aux_addr;
    logic [15:0] aux_wdata;
    logic        aux_we;
    logic        aux_gnt;
    logic [15:0] aux_rdata;
    logic        aux_rvalid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:65535];
    logic [15:0] sb [$];
    int          tests_run;
    int          tests_failed;

    mem_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .BURST_MAX   (BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .aux_req   (aux_req),
        .aux_lock  (aux_lock),
        .aux_addr  (aux_addr),
        .aux_wdata (aux_wdata),
        .aux_we    (aux_we),
        .aux_gnt   (aux_gnt),
        .aux_rdata (aux_rdata),
        .aux_rvalid(aux_rvalid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the rising edge.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [15:0] c_addr,
                                  input logic [15:0] c_wdata, input logic a_req,
                                  input logic a_lock, input logic a_we,
                                  input logic [15:0] a_addr, input logic [15:0] a_wdata);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        aux_req   = a_req;
        aux_lock  = a_lock;
        aux_we    = a_we;
        aux_addr  = a_addr;
        aux_wdata = a_wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every aux_rvalid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (aux_rvalid) begin
            if (sb.size() == 0) check_output("rvalid_unexpected", 16'd1, 16'd0);
            else check_output("aux_rdata_sb", aux_rdata, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ram[16'h0040] = 16'hBEEF;
        rst = 1'b0;
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);

        // Reset state and combinational behaviour while reset is held.
        #1;
        check_output("rst_rvalid", {15'd0, aux_rvalid}, 16'd0);
        check_output("rst_rdata", aux_rdata, 16'h0000);
        check_output("rst_gnt_idle", {15'd0, aux_gnt}, 16'd0);
        apply_stimulus(0, 0, 16'h0001, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000);
        #1;
        check_output("rst_gnt_aux", {15'd0, aux_gnt}, 16'd1);
        check_output("rst_mem_addr_aux", mem_addr, 16'h0040);
        apply_stimulus(1, 1, 16'h0001, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000);
        #1;
        check_output("rst_gnt_cpu", {15'd0, aux_gnt}, 16'd0);
        check_output("rst_mem_we_cpu", {15'd0, mem_we}, 16'd1);
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Idle-cycle aux read returns RAM data one cycle later.
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000);
        sb.push_back(16'hBEEF);
        @(negedge clk);
        check_output("idle_gnt", {15'd0, aux_gnt}, 16'd1);
        check_output("idle_stall", {15'd0, cpu_stall}, 16'd0);
        check_output("idle_mem_addr", mem_addr, 16'h0040);
        check_output("idle_mem_we", {15'd0, mem_we}, 16'd0);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_output("idle_rvalid", {15'd0, aux_rvalid}, 16'd1);
        check_output("idle_stall2", {15'd0, cpu_stall}, 16'd0);
        next_cycle();
        @(negedge clk);
        check_output("idle_rvalid_pulse", {15'd0, aux_rvalid}, 16'd0);

        // Continuous CPU traffic against an aux write: two back-to-back starvation windows.
        next_cycle();
        apply_stimulus(1, 0, 16'h0010, 16'h0000, 1, 0, 1, 16'h0020, 16'h5A5A);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < STARVE_LIMIT - 1; i++) begin
                @(negedge clk);
                check_output("starve_wait_gnt", {15'd0, aux_gnt}, 16'd0);
                check_output("starve_wait_addr", mem_addr, 16'h0010);
                next_cycle();
            end
            @(negedge clk);
`ifdef ARB_STARVE_EN
            check_output("forced_gnt", {15'd0, aux_gnt}, 16'd1);
            check_output("forced_stall", {15'd0, cpu_stall}, 16'd1);
            check_output("forced_mem_we", {15'd0, mem_we}, 16'd1);
            check_output("forced_mem_addr", mem_addr, 16'h0020);
            check_output("forced_mem_wdata", mem_wdata, 16'h5A5A);
`else
            check_output("strict_gnt", {15'd0, aux_gnt}, 16'd0);
            check_output("strict_stall", {15'd0, cpu_stall}, 16'd0);
`endif
            next_cycle();
        end
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);

        // Locked burst starting in an idle cycle, CPU requesting from the 2nd cycle on.
        next_cycle();
        apply_stimulus(0, 0, 16'h0011, 16'h0000, 1, 1, 1, 16'h0030, 16'h00AA);
        @(negedge clk);
        check_output("burst_gnt_1", {15'd0, aux_gnt}, 16'd1);
        check_output("burst_stall_1", {15'd0, cpu_stall}, 16'd0);
        next_cycle();
        apply_stimulus(1, 0, 16'h0011, 16'h0000, 1, 1, 1, 16'h0030, 16'h00AA);
        for (int i = 1; i < BURST_MAX; i++) begin
            @(negedge clk);
            check_output("burst_gnt_n", {15'd0, aux_gnt}, 16'd1);
            check_output("burst_stall_n", {15'd0, cpu_stall}, 16'd1);
            check_output("burst_addr_n", mem_addr, 16'h0030);
            next_cycle();
        end
        @(negedge clk);
        check_output("burst_end_gnt", {15'd0, aux_gnt}, 16'd0);
        check_output("burst_end_stall", {15'd0, cpu_stall}, 16'd0);
        check_output("burst_end_addr", mem_addr, 16'h0011);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);

        // Simultaneous CPU store and aux read of the same address: CPU wins first.
        next_cycle();
        apply_stimulus(1, 1, 16'h0100, 16'h1234, 1, 0, 0, 16'h0100, 16'h0000);
        sb.push_back(16'h1234);
        @(negedge clk);
        check_output("race_gnt", {15'd0, aux_gnt}, 16'd0);
        check_output("race_mem_we", {15'd0, mem_we}, 16'd1);
        check_output("race_mem_wdata", mem_wdata, 16'h1234);
        check_output("race_mem_addr", mem_addr, 16'h0100);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0100, 16'h0000);
        @(negedge clk);
        check_output("race_aux_gnt", {15'd0, aux_gnt}, 16'd1);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_output("race_rvalid", {15'd0, aux_rvalid}, 16'd1);

        // Reset asserted in the 2nd cycle of a locked read burst.
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0040, 16'h0000);
        sb.push_back(16'hBEEF);
        @(negedge clk);
        check_output("rburst_gnt_1", {15'd0, aux_gnt}, 16'd1);
        next_cycle();
        @(negedge clk);
        check_output("rburst_gnt_2", {15'd0, aux_gnt}, 16'd1);
        check_output("rburst_rdata", aux_rdata, 16'hBEEF);
        #1;
        rst = 1'b0;
        #1;
        check_output("abort_rvalid", {15'd0, aux_rvalid}, 16'd0);
        check_output("abort_rdata", aux_rdata, 16'h0000);
        apply_stimulus(1, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0040, 16'h0000);
        #1;
        check_output("abort_state_cpu", {15'd0, aux_gnt}, 16'd0);
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000);
        sb.push_back(16'hBEEF);
        @(negedge clk);
        check_output("post_rst_gnt", {15'd0, aux_gnt}, 16'd1);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        check_output("post_rst_rvalid", {15'd0, aux_rvalid}, 16'd1);

        // aux_req drops inside a locked window while the CPU is requesting.
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0050, 16'h0777);
        @(negedge clk);
        check_output("drop_gnt_1", {15'd0, aux_gnt}, 16'd1);
        next_cycle();
        apply_stimulus(1, 0, 16'h0040, 16'h0000, 0, 1, 1, 16'h0050, 16'h0777);
        @(negedge clk);
        check_output("drop_gnt", {15'd0, aux_gnt}, 16'd0);
        check_output("drop_stall", {15'd0, cpu_stall}, 16'd0);
        check_output("drop_mem_addr", mem_addr, 16'h0040);
        check_output("drop_cpu_rdata", cpu_rdata, 16'hBEEF);
        next_cycle();
        apply_stimulus(1, 0, 16'h0040, 16'h0000, 1, 1, 1, 16'h0050, 16'h0777);
        @(negedge clk);
        check_output("drop_back_to_cpu", {15'd0, aux_gnt}, 16'd0);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);

        next_cycle();
        next_cycle();
        @(negedge clk);
        check_output("sb_empty", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
